dramcon_responder: RTL and testbench

Synthesizable stand-in for the DRAM controller's user-logic port, backed by on-chip block RAM. It is the responder side of the D_ADR/D_DIN/D_WE/D_RE/D_DOUT/D_BUSY/D_DOUTVALID interface that DRAM test circuits drive. It lets user logic and test circuits run on-chip or in simulation without DDR2 calibration, using programmable calibration delay, write occupancy and read latency.

---
 rtl/dramcon_responder.sv | 151 +++++++++++++++
 tb/tb_dramcon_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dramcon_responder.sv
// dramcon_responder: block-RAM stand-in for the DRAM controller user port.
// Models calibration delay, write occupancy and fixed read latency.
module dramcon_responder #(
    parameter int unsigned ADDR_BITS      = 10,
    parameter int unsigned CALIB_CYCLES   = 16,
    parameter int unsigned WR_BUSY_CYCLES = 2,
    parameter int unsigned RD_LATENCY     = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [31:0]  D_ADR,
    input  logic [127:0] D_DIN,
    input  logic         D_WE,
    input  logic         D_RE,
    output logic [127:0] D_DOUT,
    output logic         D_BUSY,
    output logic         D_DOUTVALID,
    output logic         calib_done
);

    typedef enum logic [2:0] {
        CALIB   = 3'd0,
        IDLE    = 3'd1,
        WR_HOLD = 3'd2,
        RD_WAIT = 3'd3,
        RD_DONE = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   calib_q, calib_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [127:0]           dout_q;
    logic                   wr_en;
    logic                   rd_fire;
    logic [ADDR_BITS-1:0]   word;
    logic                   unused_adr;

    logic [127:0] mem_q [2**ADDR_BITS];

    // Byte address to word index; upper bits alias, low nibble is intra-word.
    assign word       = D_ADR[ADDR_BITS+3:4];
    assign unused_adr = ^{D_ADR[31:ADDR_BITS+4], D_ADR[3:0]};

    // State and control registers, cleared by synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= CALIB;
            cnt_q   <= 32'd0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            calib_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            calib_q <= calib_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: command acceptance, occupancy and latency counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        calib_d = calib_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        rd_fire = 1'b0;
        unique case (state_q)
            CALIB: begin
                if (cnt_q == CALIB_CYCLES - 1) begin
                    state_d = IDLE;
                    calib_d = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            IDLE, RD_DONE: begin
                state_d = IDLE;
                if (D_WE) begin
                    wr_en   = 1'b1;
                    state_d = WR_HOLD;
                    busy_d  = 1'b1;
                    cnt_d   = 32'd0;
                end else if (D_RE) begin
                    idx_d   = word;
                    state_d = RD_WAIT;
                    busy_d  = 1'b1;
                    cnt_d   = 32'd0;
                end
            end
            WR_HOLD: begin
                if (cnt_q == WR_BUSY_CYCLES - 1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RD_WAIT: begin
                if (cnt_q == RD_LATENCY - 1) begin
                    rd_fire = 1'b1;
                    valid_d = 1'b1;
                    state_d = RD_DONE;
                    busy_d  = 1'b0;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = CALIB;
                cnt_d   = 32'd0;
                busy_d  = 1'b1;
                calib_d = 1'b0;
            end
        endcase
    end

    // Storage array: written at the accept edge, never cleared by reset.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            mem_q[word] <= D_DIN;
        end
    end

    // Read data register, loaded on the final latency edge and held after.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q <= '0;
        end else if (rd_fire) begin
            dout_q <= mem_q[idx_q];
        end
    end

    assign D_DOUT      = dout_q;
    assign D_BUSY      = busy_q;
    assign D_DOUTVALID = valid_q;
    assign calib_done  = calib_q;

endmodule

// File: tb/tb_dramcon_responder.sv
// tb_dramcon_responder: directed + randomized checks of the responder
// against a word-indexed memory model and cycle-count timing rules.
module tb_dramcon_responder;

    localparam int AB = 10;
    localparam int CC = 16;
    localparam int WB = 2;
    localparam int RL = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [31:0]  D_ADR = '0;
    logic [127:0] D_DIN = '0;
    logic         D_WE = 1'b0;
    logic         D_RE = 1'b0;
    logic [127:0] D_DOUT;
    logic         D_BUSY;
    logic         D_DOUTVALID;
    logic         calib_done;

    int tests = 0;
    int fails = 0;

    logic [127:0] ref_mem [int];

    dramcon_responder #(
        .ADDR_BITS(AB),
        .CALIB_CYCLES(CC),
        .WR_BUSY_CYCLES(WB),
        .RD_LATENCY(RL)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .D_ADR(D_ADR),
        .D_DIN(D_DIN),
        .D_WE(D_WE),
        .D_RE(D_RE),
        .D_DOUT(D_DOUT),
        .D_BUSY(D_BUSY),
        .D_DOUTVALID(D_DOUTVALID),
        .calib_done(calib_done)
    );

    always #5 CLK = ~CLK;

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 32'd16) % (32'd1 << AB));
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the last reset edge.
    task automatic calib_check();
        int n;
        n = 0;
        while (calib_done === 1'b0 && n < CC + 8) begin
            check("calib_busy", D_BUSY, 1);
            check("calib_novalid", D_DOUTVALID, 0);
            n++;
            @(negedge CLK);
        end
        check("calib_len", n, CC);
        check("calib_done", calib_done, 1);
        check("calib_free", D_BUSY, 0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [127:0] d,
                            input logic also_re);
        D_ADR = a;
        D_DIN = d;
        D_WE  = 1'b1;
        D_RE  = also_re;
        @(negedge CLK);
        D_WE = 1'b0;
        D_RE = 1'b0;
        ref_mem[word_of(a)] = d;
        for (int i = 0; i < WB; i++) begin
            check("wr_busy", D_BUSY, 1);
            check("wr_novalid", D_DOUTVALID, 0);
            @(negedge CLK);
        end
        check("wr_free", D_BUSY, 0);
        check("wr_novalid_end", D_DOUTVALID, 0);
    endtask

    task automatic do_read(input logic [31:0] a);
        D_ADR = a;
        D_RE  = 1'b1;
        @(negedge CLK);
        D_RE = 1'b0;
        for (int i = 0; i < RL; i++) begin
            check("rd_busy", D_BUSY, 1);
            check("rd_novalid", D_DOUTVALID, 0);
            @(negedge CLK);
        end
        check("rd_valid", D_DOUTVALID, 1);
        check("rd_free", D_BUSY, 0);
        check("rd_data", D_DOUT, ref_mem[word_of(a)]);
        @(negedge CLK);
        check("rd_pulse_end", D_DOUTVALID, 0);
    endtask

    initial begin
        logic [127:0] d;
        logic [31:0]  a;
        logic [31:0]  b;

        // Reset values.
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_calib", calib_done, 0);
        check("rst_busy", D_BUSY, 1);
        check("rst_valid", D_DOUTVALID, 0);
        check("rst_dout", D_DOUT, 0);
        RST = 1'b0;
        calib_check();

        // Directed write/read at 0x30.
        do_write(32'h30, 128'h0000003C_00000038_00000034_00000030, 1'b0);
        do_read(32'h30);
        check("dir_0x30", D_DOUT, 128'h0000003C_00000038_00000034_00000030);

        // Sweep every word with random data; reads use aliased addresses.
        for (int i = 0; i < (1 << AB); i++) begin
            do_write(32'(i) * 32'd16, rand128(), 1'b0);
        end
        for (int i = 0; i < (1 << AB); i++) begin
            a = (32'(i) * 32'd16) | ($urandom & 32'hFFFF_C00F);
            do_read(a);
        end

        // Simultaneous strobes: write wins, no read pulse.
        d = rand128();
        do_write(32'h100, d, 1'b1);
        repeat (3) begin
            check("we_re_novalid", D_DOUTVALID, 0);
            @(negedge CLK);
        end
        do_read(32'h100);
        check("we_re_data", D_DOUT, d);

        // RE held through the busy window; re-read issued in RD_DONE.
        a = 32'h0000_0200;
        b = 32'h0000_0350;
        D_ADR = a;
        D_RE  = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < RL; i++) begin
            check("hold_busy", D_BUSY, 1);
            check("hold_novalid", D_DOUTVALID, 0);
            @(negedge CLK);
        end
        check("hold_valid", D_DOUTVALID, 1);
        check("hold_data", D_DOUT, ref_mem[word_of(a)]);
        D_ADR = b;
        @(negedge CLK);
        D_RE = 1'b0;
        for (int i = 0; i < RL; i++) begin
            check("b2b_busy", D_BUSY, 1);
            check("b2b_novalid", D_DOUTVALID, 0);
            @(negedge CLK);
        end
        check("b2b_valid", D_DOUTVALID, 1);
        check("b2b_data", D_DOUT, ref_mem[word_of(b)]);
        @(negedge CLK);
        check("b2b_pulse_end", D_DOUTVALID, 0);

        // Reset during RD_WAIT: read is abandoned, memory survives.
        D_ADR = 32'h0000_0440;
        D_RE  = 1'b1;
        @(negedge CLK);
        D_RE = 1'b0;
        check("mid_busy", D_BUSY, 1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_valid", D_DOUTVALID, 0);
        check("mid_rst_busy", D_BUSY, 1);
        check("mid_rst_calib", calib_done, 0);
        check("mid_rst_dout", D_DOUT, 0);
        RST = 1'b0;
        calib_check();
        for (int i = 0; i < 8; i++) begin
            do_read(32'($urandom_range(0, (1 << AB) - 1)) * 32'd16);
        end

        // Aliasing: 0x4000 and 0x0 are the same word.
        d = rand128();
        do_write(32'h4000, d, 1'b0);
        do_read(32'h0);
        check("alias_data", D_DOUT, d);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
